// File: rtl/cc_progress_counter_pkg.sv
// Shared race-progress definitions: FSM states, progress width, race goal,
// crash penalty and the level-comparator thresholds kept alongside the goal.
package cc_progress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } cc_state_e;

    localparam int unsigned CC_PROGRESS_W       = 8;
    localparam int unsigned CC_MAX_PROGRESS_DEF = 40;
    localparam int unsigned CC_PENALTY_DEF      = 5;
    localparam int unsigned CC_LEVEL1_THRESH    = 10;
    localparam int unsigned CC_LEVEL2_THRESH    = 30;

    typedef logic [CC_PROGRESS_W-1:0] cc_progress_t;

    // Saturating subtract: progress must never wrap below zero.
    function automatic cc_progress_t cc_sat_sub(input cc_progress_t a, input cc_progress_t b);
        return (a > b) ? cc_progress_t'(a - b) : '0;
    endfunction

endpackage

// File: rtl/cc_progress_counter_if.sv
// Control/status bundle between the race controller and the progress counter.
interface cc_progress_counter_if;
    import cc_progress_pkg::*;

    logic         start;
    logic         pause;
    logic         tick;
    logic         crash;
    cc_progress_t progress;
    logic         step;
    logic         running;
    logic         done;

    modport master (
        output start, pause, tick, crash,
        input  progress, step, running, done
    );

    modport slave (
        input  start, pause, tick, crash,
        output progress, step, running, done
    );

endinterface

// File: rtl/cc_tick_prescaler.sv
// Modulo-TICKS_PER_STEP frame-tick counter; step_o strobes on the wrapping tick.
module cc_tick_prescaler #(
    parameter int unsigned TICKS_PER_STEP = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic tick_i,
    output logic step_o
);

    localparam int unsigned CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          count;
    logic          wrap;

    assign count  = en_i && !clr_i && tick_i;
    assign wrap   = count && (cnt_q == LAST);
    assign step_o = wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || wrap) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cc_progress_counter.sv
// Race-progress counter: run/pause/done FSM, progress register and crash handling.
// Define CC_PROGRESS_COUNTER_CRASH_PENALTY_EN to make a crash also deduct PENALTY.
module cc_progress_counter
    import cc_progress_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 8,
    parameter int unsigned MAX_PROGRESS   = CC_MAX_PROGRESS_DEF,
    parameter int unsigned PENALTY        = CC_PENALTY_DEF
) (
    input  logic                     CC_PROGRESS_COUNTER_CLOCK_50,
    input  logic                     CC_PROGRESS_COUNTER_RESET_InHigh,
    input  logic                     CC_PROGRESS_COUNTER_Start_In,
    input  logic                     CC_PROGRESS_COUNTER_Pause_In,
    input  logic                     CC_PROGRESS_COUNTER_Tick_In,
    input  logic                     CC_PROGRESS_COUNTER_Crash_In,
    output logic [CC_PROGRESS_W-1:0] CC_PROGRESS_COUNTER_Progress_OutBus,
    output logic                     CC_PROGRESS_COUNTER_Step_Out,
    output logic                     CC_PROGRESS_COUNTER_Running_Out,
    output logic                     CC_PROGRESS_COUNTER_Done_Out
);

    if (TICKS_PER_STEP < 1 || TICKS_PER_STEP > 256 ||
        MAX_PROGRESS < 1 || MAX_PROGRESS > 255 || PENALTY > 255) begin : g_cfg_check
        $error("cc_progress_counter: parameter out of range");
    end

    localparam cc_progress_t MAX_C = cc_progress_t'(MAX_PROGRESS);
`ifdef CC_PROGRESS_COUNTER_CRASH_PENALTY_EN
    localparam cc_progress_t PEN_C = cc_progress_t'(PENALTY);
`endif

    cc_state_e    state_q, state_d;
    cc_progress_t prog_q, prog_d;
    logic         step_q, step_d;
    logic         running_q;
    logic         done_q;

    logic         active;
    logic         presc_en;
    logic         presc_clr;
    logic         presc_step;

    // Prescaler control is derived outside the FSM block so its strobe can be
    // consumed there without a combinational loop through the sub-module.
    assign active    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign presc_en  = (state_q == ST_RUN) && !CC_PROGRESS_COUNTER_Start_In &&
                       !CC_PROGRESS_COUNTER_Crash_In && !CC_PROGRESS_COUNTER_Pause_In;
    assign presc_clr = CC_PROGRESS_COUNTER_Start_In || (CC_PROGRESS_COUNTER_Crash_In && active);

    cc_tick_prescaler #(
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_prescaler (
        .clk_i  (CC_PROGRESS_COUNTER_CLOCK_50),
        .rst_i  (CC_PROGRESS_COUNTER_RESET_InHigh),
        .en_i   (presc_en),
        .clr_i  (presc_clr),
        .tick_i (CC_PROGRESS_COUNTER_Tick_In),
        .step_o (presc_step)
    );

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        step_d  = 1'b0;
        if (CC_PROGRESS_COUNTER_Start_In) begin
            prog_d  = '0;
            state_d = CC_PROGRESS_COUNTER_Pause_In ? ST_PAUSE : ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (CC_PROGRESS_COUNTER_Crash_In) begin
`ifdef CC_PROGRESS_COUNTER_CRASH_PENALTY_EN
                        prog_d = cc_sat_sub(prog_q, PEN_C);
`else
                        prog_d = prog_q;
`endif
                    end else if (CC_PROGRESS_COUNTER_Pause_In) begin
                        state_d = ST_PAUSE;
                    end else if (presc_step) begin
                        prog_d = prog_q + cc_progress_t'(1);
                        step_d = 1'b1;
                        if (prog_q + cc_progress_t'(1) == MAX_C) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (CC_PROGRESS_COUNTER_Crash_In) begin
`ifdef CC_PROGRESS_COUNTER_CRASH_PENALTY_EN
                        prog_d = cc_sat_sub(prog_q, PEN_C);
`else
                        prog_d = prog_q;
`endif
                    end else if (!CC_PROGRESS_COUNTER_Pause_In) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge CC_PROGRESS_COUNTER_CLOCK_50) begin
        if (CC_PROGRESS_COUNTER_RESET_InHigh) begin
            state_q   <= ST_IDLE;
            prog_q    <= '0;
            step_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prog_q    <= prog_d;
            step_q    <= step_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign CC_PROGRESS_COUNTER_Progress_OutBus = prog_q;
    assign CC_PROGRESS_COUNTER_Step_Out        = step_q;
    assign CC_PROGRESS_COUNTER_Running_Out     = running_q;
    assign CC_PROGRESS_COUNTER_Done_Out        = done_q;

endmodule

// File: doc/cc_progress_counter.md
# cc_progress_counter

Game-progress counter for the Road Fighter datapath. Turns frame-tick pulses into an 8-bit race-progress value that drives the level comparator directly, so the level rises as the player advances. Also owns the run/pause/finish state of a race and the crash penalty. Sits between the frame timer (tick source) and the level comparator (progress consumer).

## Interface
Parameters:
- TICKS_PER_STEP, 8, frame ticks per progress increment; range 1..256
- MAX_PROGRESS, 40, progress value that ends the race; range 1..255
- PENALTY, 5, progress removed per crash (only with the penalty feature)

Ports:
- CC_PROGRESS_COUNTER_CLOCK_50  in  1  system clock; all logic on the rising edge
- CC_PROGRESS_COUNTER_RESET_InHigh  in  1  synchronous, active-high reset
- CC_PROGRESS_COUNTER_Start_In  in  1  one-cycle pulse that starts or restarts a race
- CC_PROGRESS_COUNTER_Pause_In  in  1  level input; high holds progress
- CC_PROGRESS_COUNTER_Tick_In  in  1  one-cycle frame tick from the frame timer
- CC_PROGRESS_COUNTER_Crash_In  in  1  one-cycle crash pulse
- CC_PROGRESS_COUNTER_Progress_OutBus  out  8  current progress; feeds the level comparator input
- CC_PROGRESS_COUNTER_Step_Out  out  1  one-cycle pulse on each progress increment
- CC_PROGRESS_COUNTER_Running_Out  out  1  high in state RUN
- CC_PROGRESS_COUNTER_Done_Out  out  1  high in state DONE

## Operation
- States:
  - IDLE: progress is 0. Start moves to RUN.
  - RUN: tick events are counted (see below).
  - PAUSE: the prescaler and progress both hold.
  - DONE: progress holds at MAX_PROGRESS.
- Prescaler (RUN only):
  - Each Tick_In increments the prescaler.
  - When the prescaler is at TICKS_PER_STEP-1 and a tick arrives, the prescaler goes to 0, progress increments by 1, and Step_Out pulses.
- Finish: when an increment makes progress equal MAX_PROGRESS, the next state is DONE. Progress never exceeds MAX_PROGRESS.
- Pause:
  - RUN with Pause_In=1 goes to PAUSE. A tick in that same cycle is ignored.
  - PAUSE with Pause_In=0 returns to RUN.
- Start:
  - From any state, Start clears progress and the prescaler and enters RUN.
  - If Pause_In is also high, Start enters PAUSE with progress cleared.
- Crash (RUN or PAUSE only; ignored in IDLE and DONE): clears the prescaler. With the penalty feature, it also subtracts PENALTY from progress, saturating at 0.
- Priority, highest first: reset, Start, Crash, Pause, Tick.
  - Crash and a step-completing tick in the same cycle: only the crash takes effect and Step_Out stays low.
- Arithmetic:
  - Prescaler width is max(1, $clog2(TICKS_PER_STEP)).
  - Progress is 8-bit unsigned; subtraction is saturating, with no wrap-around.
  - TICKS_PER_STEP=1: every tick is a step.

## Timing
- Every output is registered.
- Reset values: Progress_OutBus=0, Step_Out=0, Running_Out=0, Done_Out=0, state IDLE, prescaler 0.
- Latency: an input event sampled at edge n is visible on the outputs after edge n, i.e. during cycle n+1.
  - Step_Out is high for exactly that one cycle, aligned with the new Progress_OutBus value.
- Done_Out rises in the same cycle that Progress_OutBus first equals MAX_PROGRESS. Running_Out falls in that same cycle.
- Reset asserted mid-race: all outputs return to their reset values after the next edge. No pending step survives.
- Tick_In is assumed to be at most one cycle wide per event. Back-to-back ticks on consecutive cycles are each counted.

## Configuration
- Macro: CC_PROGRESS_COUNTER_CRASH_PENALTY_EN.
- Defined: a crash subtracts PENALTY from progress (saturating at 0) and clears the prescaler.
- Not defined: a crash only clears the prescaler; progress is unchanged. The PENALTY parameter is unused.

## Structure
- Shared package cc_progress_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE; 2-bit encoding)
  - the progress width constant (8)
  - the default MAX_PROGRESS and PENALTY constants, so the level comparator thresholds (10, 30) and the race goal are maintained in one place
- Sub-module cc_tick_prescaler: a parameterised modulo-TICKS_PER_STEP tick counter.
  - Inputs: enable, clear, tick.
  - Output: a step strobe (combinational on the wrap tick).
- The top level holds the FSM, the progress register and the penalty logic.

## Test plan
- Reset, then Start, then 8 ticks (TICKS_PER_STEP=8) → Progress_OutBus=1 and one Step_Out pulse on the 8th tick's following cycle; Running_Out=1.
- Run 320 ticks → progress reaches 40, Done_Out=1, Running_Out=0. A further 16 ticks leave progress at 40.
- Progress=3 plus Crash with the macro defined → progress=0 (saturates, no wrap to 254), prescaler restarts. With the macro undefined → progress stays 3.
- Progress=12 with a tick completing a step plus Crash in the same cycle (macro defined) → progress=7 and no Step_Out.
- Pause high for 20 ticks mid-race → progress and prescaler unchanged. Release, then the remaining ticks complete the step on the original count.
- Start while in DONE at 40 → progress=0, Done_Out=0, Running_Out=1 next cycle. Reset mid-race at progress 25 → all outputs 0 after one edge.
